// File: rtl/regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wr_arbiter
//
// Write-port arbiter and sequencer for the CPU register file. The register
// file is eight WIDTH-bit registers indexed 0..7 = B, C, D, E, H, L, A, F.
// Several execution units share one write path. A 16-bit pair write is split
// into two beats: the high byte goes to the even register, then the low byte
// goes to the odd register. Writes to F always clear rf_wr[3:0].
//
// Build option:
//   REGARB_RR_EN  defined   -> round-robin winner selection, pointer starts at 0
//                 undefined -> fixed priority, lowest requester index wins
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   req    in   [NREQ]          per-requester write request, held until granted
//   pair   in   [NREQ]          1 = 16-bit pair write, 0 = single write
//   addr   in   [3*NREQ]        register index per requester
//   wdata  in   [2*WIDTH*NREQ]  payload per requester
//   gnt    out  [NREQ]          one-cycle one-hot grant, coincides with beat 1
//   rf_we  out  [8]             one-hot register write enables
//   rf_wr  out  [WIDTH]         shared register write data
//   busy   out                  high during BEAT1 and BEAT2
//
// States:
//   IDLE  | no write in progress; arbitrate over all requests
//   BEAT1 | first (or only) beat; gnt pulses; single writes re-arbitrate here
//   BEAT2 | odd-register beat of a pair write; re-arbitrate for the next cycle
// -----------------------------------------------------------------------------
module regfile_wr_arbiter #(
  parameter int NREQ  = 3,
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         pair,
  input  logic [3*NREQ-1:0]       addr,
  input  logic [2*WIDTH*NREQ-1:0] wdata,
  output logic [NREQ-1:0]         gnt,
  output logic [7:0]              rf_we,
  output logic [WIDTH-1:0]        rf_wr,
  output logic                    busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, BEAT1, BEAT2} state_t;

  state_t               state;
  logic [IW-1:0]        owner;
  logic                 cur_pair;
  logic [2:0]           cur_addr;
  logic [2*WIDTH-1:0]   cur_data;

`ifdef REGARB_RR_EN
  logic [IW-1:0]        ptr;
  logic [IW:0]          sum;
`endif

  // Per-requester views of the packed payload buses.
  logic [2:0]           addr_a [NREQ];
  logic [2*WIDTH-1:0]   data_a [NREQ];

  genvar g;
  generate
    for (g = 0; g < NREQ; g++) begin : g_unpack
      assign addr_a[g] = addr[3*g +: 3];
      assign data_a[g] = wdata[2*WIDTH*g +: 2*WIDTH];
    end
  endgenerate

  // The owner still holds req during its final beat, so it must not win again.
  logic                 final_beat;
  logic [NREQ-1:0]      owner_oh;
  logic [NREQ-1:0]      req_eff;

  assign final_beat = (state == BEAT2) || ((state == BEAT1) && !cur_pair);
  assign owner_oh   = NREQ'(1) << owner;
  assign req_eff    = final_beat ? (req & ~owner_oh) : req;

  logic                 found;
  logic [IW-1:0]        win;

`ifdef REGARB_RR_EN
  // First set request at or after ptr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
      if (!found && req_eff[sum[IW-1:0]]) begin
        found = 1'b1;
        win   = sum[IW-1:0];
      end
    end
  end
`else
  always_comb begin
    found = |req_eff;
    win   = '0;
    for (int i = NREQ-1; i >= 0; i--) begin
      if (req_eff[i]) win = IW'(i);
    end
  end
`endif

  function automatic logic [WIDTH-1:0] f_clear(input logic [2:0] idx,
                                               input logic [WIDTH-1:0] d);
    f_clear = (idx == 3'd7) ? {d[WIDTH-1:4], 4'b0000} : d;
  endfunction

  logic                 sel_pair;
  logic [2:0]           sel_addr;
  logic [2*WIDTH-1:0]   sel_data;
  logic [2:0]           first_idx;
  logic [WIDTH-1:0]     first_data;
  logic [2:0]           odd_idx;

  assign sel_pair   = pair[win];
  assign sel_addr   = addr_a[win];
  assign sel_data   = data_a[win];
  // Pair writes ignore addr bit 0: high byte to the even register first.
  assign first_idx  = sel_pair ? {sel_addr[2:1], 1'b0} : sel_addr;
  assign first_data = f_clear(first_idx,
                              sel_pair ? sel_data[2*WIDTH-1:WIDTH]
                                       : sel_data[WIDTH-1:0]);
  assign odd_idx    = {cur_addr[2:1], 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= '0;
      cur_pair <= 1'b0;
      cur_addr <= '0;
      cur_data <= '0;
      gnt      <= '0;
      rf_we    <= '0;
      rf_wr    <= '0;
      busy     <= 1'b0;
`ifdef REGARB_RR_EN
      ptr      <= '0;
`endif
    end else if ((state == BEAT1) && cur_pair) begin
      state <= BEAT2;
      gnt   <= '0;
      rf_we <= 8'h01 << odd_idx;
      rf_wr <= f_clear(odd_idx, cur_data[WIDTH-1:0]);
      busy  <= 1'b1;
    end else if (found) begin
      // IDLE or a final beat with a pending request: next cycle is BEAT1.
      state    <= BEAT1;
      owner    <= win;
      cur_pair <= sel_pair;
      cur_addr <= sel_addr;
      cur_data <= sel_data;
      gnt      <= NREQ'(1) << win;
      rf_we    <= 8'h01 << first_idx;
      rf_wr    <= first_data;
      busy     <= 1'b1;
`ifdef REGARB_RR_EN
      ptr      <= (win == IW'(NREQ-1)) ? '0 : win + 1'b1;
`endif
    end else begin
      state <= IDLE;
      gnt   <= '0;
      rf_we <= '0;
      rf_wr <= '0;
      busy  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
module tb_regfile_wr_arbiter;

  localparam int NREQ  = 3;
  localparam int WIDTH = 8;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [NREQ-1:0]         req = '0;
  logic [NREQ-1:0]         pair = '0;
  logic [3*NREQ-1:0]       addr = '0;
  logic [2*WIDTH*NREQ-1:0] wdata = '0;
  logic [NREQ-1:0]         gnt;
  logic [7:0]              rf_we;
  logic [WIDTH-1:0]        rf_wr;
  logic                    busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  regfile_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .pair  (pair),
    .addr  (addr),
    .wdata (wdata),
    .gnt   (gnt),
    .rf_we (rf_we),
    .rf_wr (rf_wr),
    .busy  (busy)
  );

  // Reference model: a queue of the write beats the arbiter owes, one per cycle.
  typedef struct {
    int         owner;
    logic [2:0] g;
    logic [7:0] we;
    logic [7:0] wr;
    bit         fin;
  } beat_t;

  beat_t      q[$];
  int         rr_ptr;
  logic [2:0] exp_gnt;
  logic [7:0] exp_we;
  logic [7:0] exp_wr;
  logic       exp_busy;
  logic [2:0] gprev;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] g, input logic [7:0] we,
                         input logic [7:0] wr, input logic b);
    chk({tag, "_gnt"},  32'(gnt),   32'(g));
    chk({tag, "_we"},   32'(rf_we), 32'(we));
    chk({tag, "_wr"},   32'(rf_wr), 32'(wr));
    chk({tag, "_busy"}, 32'(busy),  32'(b));
  endtask

  task automatic set_req(input int i, input logic p, input logic [2:0] a, input logic [15:0] d);
    req[i]             = 1'b1;
    pair[i]            = p;
    addr[i*3 +: 3]     = a;
    wdata[i*16 +: 16]  = d;
  endtask

  task automatic drop(input int i);
    req[i] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0; pair = '0; addr = '0; wdata = '0;
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    rr_ptr = 0;
    gprev  = '0;
  endtask

  function automatic logic [7:0] reg_val(input int idx, input logic [7:0] v);
    reg_val = (idx == 7) ? (v & 8'hF0) : v;
  endfunction

  task automatic push_beat(input int w, input bit first, input int idx, input logic [7:0] v,
                           input bit fin);
    beat_t b;
    b.owner = w;
    b.g     = first ? 3'(1 << w) : 3'b000;
    b.we    = 8'(1 << idx);
    b.wr    = reg_val(idx, v);
    b.fin   = fin;
    q.push_back(b);
  endtask

  task automatic push_write(input int w);
    int          a;
    logic [15:0] d;
    a = int'(addr[w*3 +: 3]);
    d = wdata[w*16 +: 16];
    if (pair[w]) begin
      push_beat(w, 1'b1, (a / 2) * 2,     d[15:8], 1'b0);
      push_beat(w, 1'b0, (a / 2) * 2 + 1, d[7:0],  1'b1);
    end else begin
      push_beat(w, 1'b1, a, d[7:0], 1'b1);
    end
  endtask

  function automatic int pick(input logic [2:0] elig);
    pick = -1;
`ifdef REGARB_RR_EN
    for (int k = 0; k < NREQ; k++) begin
      if (pick < 0 && elig[(rr_ptr + k) % NREQ]) pick = (rr_ptr + k) % NREQ;
    end
`else
    for (int k = NREQ-1; k >= 0; k--) begin
      if (elig[k]) pick = k;
    end
`endif
  endfunction

  // Called at the active edge with the inputs the DUT is sampling.
  task automatic model_step();
    beat_t      cur;
    bit         have;
    logic [2:0] elig;
    int         w;
    have = (q.size() > 0);
    if (have) cur = q.pop_front();
    if (q.size() == 0) begin
      elig = req;
      if (have && cur.fin) elig[cur.owner] = 1'b0;
      w = pick(elig);
      if (w >= 0) begin
        push_write(w);
        rr_ptr = (w + 1) % NREQ;
      end
    end
    if (q.size() > 0) begin
      exp_gnt = q[0].g; exp_we = q[0].we; exp_wr = q[0].wr; exp_busy = 1'b1;
    end else begin
      exp_gnt = '0; exp_we = '0; exp_wr = '0; exp_busy = 1'b0;
    end
  endtask

  int ord[6];

  initial begin
    // Reset state
    do_reset();
    rst_n = 1'b0;
    tick();
    chk_out("reset", 3'b000, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single write of A by requester 1
    set_req(1, 1'b0, 3'd6, 16'h00A5);
    tick();
    chk_out("single_a", 3'b010, 8'h40, 8'hA5, 1'b1);
    tick();
    chk_out("single_a_idle", 3'b000, 8'h00, 8'h00, 1'b0);
    drop(1);

    // Pair write to DE from requester 0, addr bit 0 ignored
    set_req(0, 1'b1, 3'd3, 16'h1234);
    tick();
    chk_out("pair_b1", 3'b001, 8'h04, 8'h12, 1'b1);
    tick();
    chk_out("pair_b2", 3'b000, 8'h08, 8'h34, 1'b1);
    drop(0);
    tick();
    chk_out("pair_idle", 3'b000, 8'h00, 8'h00, 1'b0);

    // Write to F clears the low nibble
    set_req(2, 1'b0, 3'd7, 16'h00FF);
    tick();
    chk_out("f_reg", 3'b100, 8'h80, 8'hF0, 1'b1);
    tick();
    drop(2);

    // All three requesting singles continuously
`ifdef REGARB_RR_EN
    ord = '{0, 1, 2, 0, 1, 2};
`else
    ord = '{0, 1, 0, 1, 0, 1};
`endif
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 3'(i), 16'(8'h10 + i));
    for (int k = 0; k < 6; k++) begin
      tick();
      chk_out($sformatf("order%0d", k), 3'(1 << ord[k]), 8'(1 << ord[k]),
              8'(8'h10 + ord[k]), 1'b1);
    end
    do_reset();
    tick();

    // Pair to HL, then a queued single to B with no idle gap
    set_req(2, 1'b1, 3'd4, 16'hABCD);
    tick();
    chk_out("hl_b1", 3'b100, 8'h10, 8'hAB, 1'b1);
    set_req(0, 1'b0, 3'd0, 16'h0055);
    tick();
    chk_out("hl_b2", 3'b000, 8'h20, 8'hCD, 1'b1);
    drop(2);
    tick();
    chk_out("b_after_pair", 3'b001, 8'h01, 8'h55, 1'b1);
    tick();
    chk_out("b_idle", 3'b000, 8'h00, 8'h00, 1'b0);
    drop(0);

    // Reset during BEAT1 of a pair abandons BEAT2
    set_req(1, 1'b1, 3'd2, 16'h7788);
    tick();
    chk_out("rst_pair_b1", 3'b010, 8'h04, 8'h77, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 3'b000, 8'h00, 8'h00, 1'b0);
    req = '0; pair = '0; addr = '0; wdata = '0;
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_out("no_beat2", 3'b000, 8'h00, 8'h00, 1'b0);
    set_req(0, 1'b0, 3'd5, 16'h0011);
    tick();
    chk_out("after_rst", 3'b001, 8'h20, 8'h11, 1'b1);
    tick();
    chk_out("after_rst_idle", 3'b000, 8'h00, 8'h00, 1'b0);
    drop(0);

    // Randomized traffic against the beat-queue model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      model_step();
      #1;
      chk("rnd_gnt",  32'(gnt),   32'(exp_gnt));
      chk("rnd_we",   32'(rf_we), 32'(exp_we));
      chk("rnd_wr",   32'(rf_wr), 32'(exp_wr));
      chk("rnd_busy", 32'(busy),  32'(exp_busy));
      chk("rnd_we_onehot0", 32'($onehot0(rf_we)), 32'd1);
      for (int i = 0; i < NREQ; i++) if (gprev[i]) req[i] = 1'b0;
      gprev = exp_gnt;
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && $urandom_range(0, 2) == 0)
          set_req(i, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  16'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
